// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the elastic register pipeline.
package pipe_pkg;

  localparam int unsigned DefaultWidth    = 8;
  localparam int unsigned DefaultDepth    = 3;
  localparam int unsigned DefaultResetVal = 0;

  // Occupancy counter operation chosen each cycle
  typedef enum logic [1:0] {
    OccHold,
    OccInc,
    OccDec,
    OccClr
  } occ_op_e;

  // Width needed to count 0..n inclusive
  function automatic int unsigned clog2_p1(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One elastic pipeline stage: a valid bit and a data register with upstream handshake.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = DefaultWidth,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DefaultResetVal)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush_i,
  input  logic             rdy_i,
  input  logic             up_valid_i,
  input  logic [WIDTH-1:0] up_data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
      data_d  = RESET_VAL;
    end else if (rdy_i) begin
      valid_d = up_valid_i;
      // Data only moves with a valid word so bubbles do not toggle the register
      if (up_valid_i) begin
        data_d = up_data_i;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= RESET_VAL;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_reg_chain.sv
// Elastic DEPTH-stage register pipeline with bubble collapsing, flush and occupancy count.
module pipe_reg_chain
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = DefaultWidth,
  parameter int unsigned      DEPTH     = DefaultDepth,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DefaultResetVal)
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [clog2_p1(DEPTH)-1:0]   occupancy
);

  localparam int unsigned OccW = clog2_p1(DEPTH);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] up_v;
  logic [WIDTH-1:0] d    [DEPTH];
  logic [WIDTH-1:0] up_d [DEPTH];

  logic            push, pop;
  occ_op_e         occ_op;
  logic [OccW-1:0] occ_q, occ_d;

  // A stage is ready if it is empty or anything downstream of it will move
  always_comb begin : ready_chain
    logic acc;
    acc = out_ready;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      acc    = acc | ~v[i];
      rdy[i] = acc;
    end
  end

  always_comb begin
    up_v[0] = in_valid;
    up_d[0] = in_data;
    for (int i = 1; i < int'(DEPTH); i++) begin
      up_v[i] = v[i-1];
      up_d[i] = d[i-1];
    end
  end

  for (genvar g = 0; g < int'(DEPTH); g++) begin : g_stage
    pipe_stage #(
      .WIDTH    (WIDTH),
      .RESET_VAL(RESET_VAL)
    ) u_stage (
      .clock     (clock),
      .reset_n   (reset_n),
      .flush_i   (flush),
      .rdy_i     (rdy[g]),
      .up_valid_i(up_v[g]),
      .up_data_i (up_d[g]),
      .valid_o   (v[g]),
      .data_o    (d[g])
    );
  end

  assign in_ready  = rdy[0] & ~flush & reset_n;
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

  assign push = in_valid & in_ready;
  assign pop  = v[DEPTH-1] & out_ready;

  always_comb begin
    occ_op = OccHold;
    if (flush) begin
      occ_op = OccClr;
    end else if (push && !pop) begin
      occ_op = OccInc;
    end else if (pop && !push) begin
      occ_op = OccDec;
    end
  end

  always_comb begin
    occ_d = occ_q;
    unique case (occ_op)
      OccInc:  occ_d = occ_q + OccW'(1);
      OccDec:  occ_d = occ_q - OccW'(1);
      OccClr:  occ_d = '0;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;

endmodule
